// File: rtl/rca_stim_chk.sv
// Exhaustive stimulus/checker for an N-bit ripple-carry adder: walks {A,B,Cin} through every
// vector, compares {Cout,SUM} to A+B+Cin. Optional macro RCA_STIM_CHK_STOP_ON_FAIL_EN ends a run at the first mismatch.
module rca_stim_chk #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [N-1:0]   A,
  output logic [N-1:0]   B,
  output logic           Cin,
  input  logic [N-1:0]   SUM,
  input  logic           Cout,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [15:0]    err_cnt,
  output logic [2*N:0]   first_fail,
  output logic           first_fail_vld
);
  localparam int IW = 2*N+1;

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic [3:0]    settle_cnt;
  logic [N:0]    ref_sum;
  logic          mismatch;
  logic          last;
  logic          stop;

  // operands come straight from the registered index, so they hold in IDLE
  assign {A, B, Cin} = idx;
  assign ref_sum  = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};
  assign mismatch = ({Cout, SUM} != ref_sum);
  assign last     = &idx;

`ifdef RCA_STIM_CHK_STOP_ON_FAIL_EN
  assign stop = mismatch;
`else
  assign stop = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = WAIT;
      WAIT:  begin
        busy = 1'b1;
        if (settle_cnt == 4'd1) state_nx = CHECK;
      end
      CHECK: begin
        busy     = 1'b1;
        state_nx = (last || stop) ? DONE : WAIT;
      end
      DONE:  begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx            <= '0;
      settle_cnt     <= '0;
      err_cnt        <= '0;
      pass           <= 1'b0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx            <= '0;
          err_cnt        <= '0;
          first_fail_vld <= 1'b0;
          pass           <= 1'b0;
          settle_cnt     <= 4'(SETTLE);
        end
        WAIT: settle_cnt <= settle_cnt - 4'd1;
        CHECK: begin
          if (mismatch) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (!first_fail_vld) begin
              first_fail     <= idx;
              first_fail_vld <= 1'b1;
            end
          end
          // the all-ones vector is terminal; idx must not wrap and re-drive vector 0
          if (!(last || stop)) begin
            idx        <= idx + IW'(1);
            settle_cnt <= 4'(SETTLE);
          end
        end
        // err_cnt already includes any mismatch from the final CHECK
        DONE: pass <= (err_cnt == 16'd0);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rca_stim_chk.sv
// Scoreboard bench for rca_stim_chk: randomized faulty-adder runs, expected results from a vector-walk model.
module tb_rca_stim_chk;
  localparam int N      = 2;
  localparam int SETTLE = 1;
  localparam int NV     = 1 << (2*N+1);

  logic           clk = 1'b0;
  logic           rst, start;
  logic [N-1:0]   A, B, SUM;
  logic           Cin, Cout, busy, done, pass, first_fail_vld;
  logic [15:0]    err_cnt;
  logic [2*N:0]   first_fail;

  int             mode = 0;
  logic [NV-1:0]  badmap = '0;
  int             cyc = 0;
  int             checks = 0;
  int             failures = 0;

  typedef struct {
    int err; int pass; int ffv; int ff; int lat; int c0; int nvec;
  } exp_t;
  exp_t q[$];

  rca_stim_chk #(.N(N), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .SUM(SUM), .Cout(Cout), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_fail(first_fail), .first_fail_vld(first_fail_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // adder under test: 0 good, 1 SUM[0] stuck 0, 2 Cout inverted, 3 random vectors corrupted
  function automatic logic [N:0] adder_out(int m, logic [NV-1:0] bm, int v);
    int s;
    s = (v >> (N+1)) + ((v >> 1) % (1 << N)) + (v % 2);
    case (m)
      1: s = s & ~1;
      2: s = s ^ (1 << N);
      3: if (bm[v]) s = s ^ (1 << (v % (N+1)));
      default: ;
    endcase
    return (N+1)'(s);
  endfunction

  assign {Cout, SUM} = adder_out(mode, badmap, int'({A, B, Cin}));

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // monitor: pops on each done pulse, checks latency then, and the held results one cycle later
  exp_t          cur;
  bit            pend = 0;
  logic [NV-1:0] seen = '0;
  always @(negedge clk) begin
    if (rst) begin
      seen = '0;
      pend = 0;
    end else begin
      if (pend) begin
        pend = 0;
        chk("done_width", int'(done), 0);
        chk("err_cnt", int'(err_cnt), cur.err);
        chk("pass", int'(pass), cur.pass);
        chk("first_fail_vld", int'(first_fail_vld), cur.ffv);
        if (cur.ffv != 0) chk("first_fail", int'(first_fail), cur.ff);
        chk("vectors_applied", $countones(seen), cur.nvec);
        seen = '0;
      end else if (done) begin
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          cur = q.pop_front();
          chk("done_latency", cyc - cur.c0, cur.lat);
          pend = 1;
        end
      end
      if (busy) seen[int'({A, B, Cin})] = 1'b1;
    end
  end

  task automatic run(int m, bit rep);
    exp_t e;
    int   want, n;
    mode = m;
    for (int v = 0; v < NV; v++) badmap[v] = ($urandom_range(0, 5) == 0);
    e.err = 0; e.ffv = 0; e.ff = 0; e.nvec = NV;
    for (int v = 0; v < NV; v++) begin
      want = (v >> (N+1)) + ((v >> 1) & ((1 << N) - 1)) + (v & 1);
      if (int'(adder_out(m, badmap, v)) != want) begin
        e.err++;
        if (e.ffv == 0) begin e.ffv = 1; e.ff = v; end
`ifdef RCA_STIM_CHK_STOP_ON_FAIL_EN
        e.nvec = v + 1;
        break;
`endif
      end
    end
    e.pass = (e.err == 0);
    e.lat  = e.nvec * (SETTLE+1) + 1;
    @(negedge clk);
    start = 1'b1;
    e.c0  = cyc;
    q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = rep && (n == 10 || n == 30);
    end while (!done && n < 5000);
    start = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({A, B, Cin, busy, done, pass, err_cnt, first_fail, first_fail_vld}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(0, 0);
    run(1, 0);
    run(2, 0);
    for (int i = 0; i < 6; i++) run($urandom_range(0, 3), 1'($urandom_range(0, 1)));

    // abort mid-run: no expectation queued, so any done pulse is flagged by the monitor
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1 chk("midrun_reset_outputs", int'({A, B, Cin, busy, done, pass, err_cnt, first_fail, first_fail_vld}), 0);
    repeat (3) @(negedge clk);
    chk("reset_held_outputs", int'({busy, done, pass, err_cnt, first_fail_vld}), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_autostart", int'(busy), 0);

    run(0, 0);
    run(0, 1);
    run(3, 1);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
